ifetch_queue: RTL and testbench

Instruction-fetch stage placed directly upstream of the MIPS core. It issues sequential word fetches to instruction memory and buffers returned words with their PCs in a DEPTH-entry queue. It presents them to decode with a valid/ready handshake and flushes on branch/jump redirect. The credit scheme decouples variable-latency instruction memory from core stalls without ever overflowing.

---
 rtl/ifetch_queue.sv | 117 +++++++++++
 tb/tb_ifetch_queue.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction-fetch queue: credit-limited sequential fetch, DEPTH-entry buffer, redirect flush.
// Optional IFQ_STATS_EN adds fetch_count/stall_count performance counters.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
`ifdef IFQ_STATS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outst;
    logic [CW-1:0] drop;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [31:0]   pc_q    [DEPTH];
    logic [31:0]   instr_q [DEPTH];

    logic [CW:0]   credit;
    logic [31:0]   tgt_pc;
    logic          accept;
    logic          rv;
    logic          keep;
    logic          pop;

    assign credit    = {1'b0, count} + {1'b0, outst};
    assign tgt_pc    = redirect_pc & 32'hFFFF_FFFC;
    assign imem_req  = !reset && !redirect && (credit < DEPTH_C);
    assign imem_addr = fetch_pc;
    assign accept    = imem_req && imem_ack;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rv        = imem_rvalid && (outst != '0);
    assign keep      = rv && (drop == '0) && !redirect;
    assign pop       = out_valid && out_ready && !redirect;

    assign out_valid = (count != '0);
    assign out_pc    = out_valid ? pc_q[head] : 32'h0;
    assign out_instr = out_valid ? instr_q[head] : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            count    <= '0;
            outst    <= '0;
            drop     <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            outst <= outst + CW'(accept) - CW'(rv);
            if (redirect) begin
                // Every response still in flight belongs to the old stream.
                fetch_pc <= tgt_pc;
                resp_pc  <= tgt_pc;
                count    <= '0;
                head     <= tail;
                drop     <= outst - CW'(rv);
            end else begin
                if (accept)
                    fetch_pc <= fetch_pc + 32'd4;
                if (rv && (drop != '0))
                    drop <= drop - CW'(1);
                if (keep) begin
                    tail    <= tail + AW'(1);
                    resp_pc <= resp_pc + 32'd4;
                end
                if (pop)
                    head <= head + AW'(1);
                count <= count + CW'(keep) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (keep) begin
            pc_q[tail]    <= resp_pc;
            instr_q[tail] <= imem_rdata;
        end
    end

`ifdef IFQ_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (out_valid && out_ready)
                fetch_count <= fetch_count + 32'd1;
            if (out_ready && !out_valid)
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: in-order memory model, redirect flushes, stall/hold checks.
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
`ifdef IFQ_STATS_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr)
`ifdef IFQ_STATS_EN
        ,
        .fetch_count (fetch_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    mreq_t       mq[$];
    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          lat = 1;
    bit          ack_en = 1'b1;
    bit          rdy = 1'b1;
    bit          rd_pulse = 1'b0;
    logic [31:0] rd_tgt = 32'h0;
    int          outst_m = 0;
    int          nreq = 0;
    int          nout = 0;
    int          fetch_m = 0;
    int          stall_m = 0;
    bit          want_first = 1'b0;
    logic [31:0] first_exp;
    bit          chk_after = 1'b0;
    logic [31:0] after_addr;
    int          drop_exp;
    bit          hold_v = 1'b0;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        mreq_t m;
        exp_t  e;
        bit    acc;
        @(negedge clk);
        if (mq.size() > 0 && mq[0].due <= edges + 1) begin
            m = mq.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = memf(m.addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        imem_ack    = ack_en;
        out_ready   = rdy;
        redirect    = rd_pulse;
        redirect_pc = rd_tgt;
        #1;
        assert (!(imem_rvalid && outst_m == 0))
            else $error("rvalid with nothing outstanding");
        if (chk_after) begin
            chk("redir_valid", 32'(out_valid), 32'd0);
            chk("redir_addr", imem_addr, after_addr);
            chk("redir_drop", 32'(dut.drop), 32'(drop_exp));
            chk_after = 1'b0;
        end
        if (hold_v && out_valid) begin
            chk("hold_pc", out_pc, hold_pc);
            chk("hold_instr", out_instr, hold_instr);
        end
        acc = imem_req && imem_ack;
        if (acc) begin
            m.due  = edges + 1 + lat;
            m.addr = imem_addr;
            mq.push_back(m);
            e.pc    = imem_addr;
            e.instr = memf(imem_addr);
            sb.push_back(e);
            nreq++;
        end
        if (out_valid && out_ready) fetch_m++;
        if (out_ready && !out_valid) stall_m++;
        if (redirect) begin
            sb.delete();
            drop_exp   = outst_m - (imem_rvalid ? 1 : 0);
            after_addr = rd_tgt & 32'hFFFF_FFFC;
            chk_after  = 1'b1;
            want_first = 1'b1;
            first_exp  = after_addr;
        end else if (out_valid && out_ready) begin
            nout++;
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("out_pc", out_pc, e.pc);
                chk("out_instr", out_instr, e.instr);
                if (want_first) begin
                    chk("first_pc", out_pc, first_exp);
                    want_first = 1'b0;
                end
            end
        end
        hold_v     = out_valid && !out_ready && !redirect;
        hold_pc    = out_pc;
        hold_instr = out_instr;
        outst_m    = outst_m + (acc ? 1 : 0) - (imem_rvalid ? 1 : 0);
        rd_pulse   = 1'b0;
    endtask

    task automatic clear_model();
        mq.delete();
        sb.delete();
        outst_m    = 0;
        fetch_m    = 0;
        stall_m    = 0;
        hold_v     = 1'b0;
        chk_after  = 1'b0;
        want_first = 1'b1;
        first_exp  = 32'h0;
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int first_v;
        int n;
        int lim;
        bit found;
        logic [31:0] a0;

        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        out_ready   = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_instr", out_instr, 32'h0);
`ifdef IFQ_STATS_EN
        chk("rst_fcnt", fetch_count, 32'h0);
        chk("rst_scnt", stall_count, 32'h0);
`endif

        // Streaming with single-cycle memory
        release_reset();
        base    = edges;
        first_v = -1;
        n       = 0;
        for (int i = 0; i < 20; i++) begin
            nout = 0;
            tick();
            if (i == 0) begin
                chk("first_req", 32'(imem_req), 32'd1);
                chk("first_addr", imem_addr, 32'h0);
            end
            if (out_valid && first_v < 0) first_v = edges + 1 - base;
            if (i >= 5) n += nout;
        end
        chk("fill_lat", 32'(first_v), 32'd3);
        chk("thruput", 32'(n), 32'd15);

        // Decode stalled: credits cap requests at DEPTH
        rdy      = 1'b0;
        rd_tgt   = 32'h100;
        rd_pulse = 1'b1;
        tick();
        nreq = 0;
        repeat (10) tick();
        chk("stall_reqs", 32'(nreq), 32'd4);
        chk("stall_idle", 32'(imem_req), 32'd0);
        chk("stall_full", 32'(out_valid), 32'd1);
        rdy  = 1'b1;
        nout = 0;
        repeat (12) tick();
        chk("drain_cnt", 32'(nout >= 4), 32'd1);

        // Latency 3, redirect with requests in flight
        lat = 3;
        repeat (8) tick();
        rd_tgt   = 32'h40;
        rd_pulse = 1'b1;
        tick();
        repeat (15) tick();

        // Redirect coinciding with a response, unaligned target
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mq.size() > 0 && mq[0].due <= edges + 2) begin
                rd_tgt   = 32'h43;
                rd_pulse = 1'b1;
                found    = 1'b1;
            end
            tick();
        end
        chk("rv_align", 32'(found), 32'd1);
        repeat (15) tick();

        // Memory refuses requests
        lat    = 1;
        ack_en = 1'b0;
        tick();
        a0 = imem_addr;
        repeat (5) begin
            tick();
            chk("ack_hold", imem_addr, a0);
        end
        ack_en = 1'b1;
        repeat (10) tick();

        // Fresh run, starved then streaming, then async reset mid-cycle
        reset = 1'b1;
        clear_model();
        release_reset();
        rdy = 1'b1;
        repeat (8) tick();
        @(posedge clk);
        #1;
`ifdef IFQ_STATS_EN
        chk("fetch_count", fetch_count, 32'(fetch_m));
        chk("stall_count", stall_count, 32'(stall_m));
`endif
        lim = 0;
        while (!out_valid && lim < 10) begin
            tick();
            lim++;
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_addr", imem_addr, 32'h0);
`ifdef IFQ_STATS_EN
        chk("mid_rst_fcnt", fetch_count, 32'h0);
        chk("mid_rst_scnt", stall_count, 32'h0);
`endif
        clear_model();
        release_reset();
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
